// File: rtl/tick_counter_ctrl_pkg.sv
// Shared state encodings for the tick counter controller.
// 2'b11 is never produced; the FSM recovers from it to S_STOP.
package tick_counter_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_STOP = 2'b00;
    localparam state_t S_UP   = 2'b01;
    localparam state_t S_DOWN = 2'b10;

endpackage

// File: rtl/tick_counter_ctrl_press_edge_sync.sv
// 2-FF synchronizer plus falling-edge detector for an active-low button.
// o_press is high in the cycle before the edge that acts on it (2 edges after the input is first sampled low).
module press_edge_sync (
    input  logic out_clk_tb,
    input  logic rst_n,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_press
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // All stages reset to the released level so a button held through reset
    // still shows one clean 1->0 transition after release.
    always_ff @(posedge out_clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_btn_n;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_press = r_prev & ~r_sync;

endmodule

// File: rtl/tick_counter_ctrl.sv
// Run/stop/direction FSM and bounded up/down counter driven by synchronized button presses.
// All outputs registered; a press acts on the second edge after it is first sampled.
module tick_counter_ctrl
    import tick_counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LOWER = 0,
    parameter int UPPER = 15
) (
    input  logic             out_clk_tb,
    input  logic             rst_n,
    input  logic             dir_btn_n,
    input  logic             stop_btn_n,
    input  logic             clr_btn_n,
    input  logic             bounce,
    output logic [WIDTH-1:0] counter,
    output logic             dir,
    output logic             running,
    output logic             bound_pulse,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] LO    = WIDTH'(LOWER);
    localparam logic [WIDTH-1:0] HI    = WIDTH'(UPPER);
    localparam logic [WIDTH-1:0] LO_P1 = WIDTH'(LOWER + 1);
    localparam logic [WIDTH-1:0] HI_M1 = WIDTH'(UPPER - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic w_dir_evt;
    logic w_stop_evt;
    logic w_clr_evt;
    logic w_bounce_lvl;
    logic w_dir_lvl_unused;
    logic w_stop_lvl_unused;
    logic w_clr_lvl_unused;
    logic w_bounce_press_unused;

    press_edge_sync u_dir_sync (
        .out_clk_tb (out_clk_tb),
        .rst_n      (rst_n),
        .i_btn_n    (dir_btn_n),
        .o_level    (w_dir_lvl_unused),
        .o_press    (w_dir_evt)
    );

    press_edge_sync u_stop_sync (
        .out_clk_tb (out_clk_tb),
        .rst_n      (rst_n),
        .i_btn_n    (stop_btn_n),
        .o_level    (w_stop_lvl_unused),
        .o_press    (w_stop_evt)
    );

    press_edge_sync u_clr_sync (
        .out_clk_tb (out_clk_tb),
        .rst_n      (rst_n),
        .i_btn_n    (clr_btn_n),
        .o_level    (w_clr_lvl_unused),
        .o_press    (w_clr_evt)
    );

    press_edge_sync u_bounce_sync (
        .out_clk_tb (out_clk_tb),
        .rst_n      (rst_n),
        .i_btn_n    (bounce),
        .o_level    (w_bounce_lvl),
        .o_press    (w_bounce_press_unused)
    );

    logic [WIDTH-1:0] r_counter;
    logic             r_dir;
    logic             r_running;
    logic             r_bound_pulse;
    state_t           r_state;

    logic             w_run_now;
    logic             w_up;
    logic             w_at_bound;
    logic             w_step;
    logic             w_hit;
    logic             w_bounce_rev;
    logic             w_dir_next;
    logic             w_run_next;
    logic [WIDTH-1:0] w_cnt_next;
    state_t           w_state_next;

    always_comb begin
        w_run_now    = (r_state == S_UP) || (r_state == S_DOWN);
        w_up         = (r_state == S_UP);
        w_at_bound   = w_up ? (r_counter == HI) : (r_counter == LO);
        // Clear takes the edge: no step, hence no bound hit or reversal.
        w_step       = w_run_now && !w_clr_evt;
        w_hit        = w_step && w_at_bound;
        w_bounce_rev = w_hit && w_bounce_lvl;

        w_cnt_next = r_counter;
        if (w_clr_evt) begin
            w_cnt_next = LO;
        end else if (w_step) begin
            if (w_hit) begin
                if (w_bounce_lvl) w_cnt_next = w_up ? HI_M1 : LO_P1;
                else              w_cnt_next = w_up ? LO : HI;
            end else begin
                w_cnt_next = w_up ? (r_counter + ONE) : (r_counter - ONE);
            end
        end

        // A dir press and a bounce reversal on the same edge cancel.
        w_dir_next = r_dir ^ w_dir_evt ^ w_bounce_rev;
        w_run_next = w_run_now ^ w_stop_evt;

        if (r_state == S_STOP || w_run_now) begin
            w_state_next = w_run_next ? (w_dir_next ? S_UP : S_DOWN) : S_STOP;
        end else begin
            w_run_next   = 1'b0;
            w_state_next = S_STOP;
        end
    end

    always_ff @(posedge out_clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            r_counter     <= LO;
            r_state       <= S_UP;
            r_dir         <= 1'b1;
            r_running     <= 1'b1;
            r_bound_pulse <= 1'b0;
        end else begin
            r_counter     <= w_cnt_next;
            r_state       <= w_state_next;
            r_dir         <= w_dir_next;
            r_running     <= w_run_next;
            r_bound_pulse <= w_hit;
        end
    end

    assign counter     = r_counter;
    assign dir         = r_dir;
    assign running     = r_running;
    assign bound_pulse = r_bound_pulse;
    assign state       = r_state;

endmodule

// File: tb/tb_tick_counter_ctrl.sv
// Bench for tick_counter_ctrl: table-driven free-run sweeps plus hand sequences for
// press latency, held buttons, simultaneous events, bounce cancellation, clear and async reset.
module tb_tick_counter_ctrl;
    import tick_counter_ctrl_pkg::*;

    logic       out_clk_tb = 1'b0;
    logic       rst_n      = 1'b0;
    logic       dir_btn_n  = 1'b1;
    logic       stop_btn_n = 1'b1;
    logic       clr_btn_n  = 1'b1;
    logic       bounce     = 1'b0;
    logic [3:0] counter;
    logic       dir;
    logic       running;
    logic       bound_pulse;
    logic [1:0] state;

    always #5 out_clk_tb = ~out_clk_tb;

    tick_counter_ctrl #(.WIDTH(4), .LOWER(0), .UPPER(15)) dut (
        .out_clk_tb  (out_clk_tb),
        .rst_n       (rst_n),
        .dir_btn_n   (dir_btn_n),
        .stop_btn_n  (stop_btn_n),
        .clr_btn_n   (clr_btn_n),
        .bounce      (bounce),
        .counter     (counter),
        .dir         (dir),
        .running     (running),
        .bound_pulse (bound_pulse),
        .state       (state)
    );

    typedef struct packed {
        logic [3:0] cnt;
        logic       dir;
        logic       run;
        logic       bp;
        logic [1:0] st;
    } exp_t;

    typedef struct {
        logic rst;
        logic dir_n;
        logic stop_n;
        logic clr_n;
        logic bnc;
        exp_t e;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk(int c, logic d, logic r, logic b, state_t s);
        exp_t e;
        e.cnt = c[3:0];
        e.dir = d;
        e.run = r;
        e.bp  = b;
        e.st  = s;
        return e;
    endfunction

    function automatic exp_t up(int c, logic b);
        return mk(c, 1'b1, 1'b1, b, S_UP);
    endfunction

    function automatic exp_t dn(int c, logic b);
        return mk(c, 1'b0, 1'b1, b, S_DOWN);
    endfunction

    function automatic vec_t mkv(logic r, logic d, logic s, logic c, logic b, exp_t e);
        vec_t v;
        v.rst = r; v.dir_n = d; v.stop_n = s; v.clr_n = c; v.bnc = b; v.e = e;
        return v;
    endfunction

    task automatic compare(string name);
        exp_t e;
        exp_t a;
        a.cnt = counter;
        a.dir = dir;
        a.run = running;
        a.bp  = bound_pulse;
        a.st  = state;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: no expected value queued", name);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got cnt=%0d dir=%b run=%b bp=%b st=%b, want cnt=%0d dir=%b run=%b bp=%b st=%b",
                         name, a.cnt, a.dir, a.run, a.bp, a.st, e.cnt, e.dir, e.run, e.bp, e.st);
            end
        end
    endtask

    task automatic drive(logic d, logic s, logic c, logic b);
        dir_btn_n  = d;
        stop_btn_n = s;
        clr_btn_n  = c;
        bounce     = b;
    endtask

    task automatic step(string name, exp_t e);
        exp_q.push_back(e);
        @(posedge out_clk_tb);
        #1;
        compare(name);
    endtask

    // Reset asserted and released between edges; checked both while held and after release.
    task automatic do_reset(string name, exp_t e);
        @(posedge out_clk_tb);
        #2 rst_n = 1'b0;
        #2;
        exp_q.push_back(e);
        compare({name, "_held"});
        #2 rst_n = 1'b1;
        #1;
        exp_q.push_back(e);
        compare({name, "_rel"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        exp_t R;
        exp_t S;
        R = up(0, 1'b0);

        // Free-run sweeps: wrap mode, then ping-pong mode.
        tbl.push_back(mkv(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, R));
        for (int i = 1; i <= 19; i++)
            tbl.push_back(mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, up(i % 16, i == 16)));
        tbl.push_back(mkv(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, R));
        for (int i = 1; i <= 19; i++) begin
            if (i <= 15)      tbl.push_back(mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, up(i, 1'b0)));
            else if (i == 16) tbl.push_back(mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, dn(14, 1'b1)));
            else              tbl.push_back(mkv(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, dn(30 - i, 1'b0)));
        end

        foreach (tbl[i]) begin
            drive(tbl[i].dir_n, tbl[i].stop_n, tbl[i].clr_n, tbl[i].bnc);
            if (tbl[i].rst) do_reset($sformatf("tbl%0d_rst", i), tbl[i].e);
            else            step($sformatf("tbl%0d", i), tbl[i].e);
        end

        // Stop press: acts two edges after first sampled, held press is one event.
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        do_reset("C_rst", R);
        for (int c = 1; c <= 4; c++) step("C_pre", up(c, 1'b0));
        S = mk(7, 1'b1, 1'b0, 1'b0, S_STOP);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        step("C_sample", up(5, 1'b0));
        step("C_sync", up(6, 1'b0));
        step("C_stop_evt", S);
        step("C_held", S);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        step("C_idle", S);
        step("C_idle", S);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        step("C_wait", S);
        step("C_wait", S);
        step("C_resume", up(7, 1'b0));
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        step("C_after", up(8, 1'b0));

        // Dir held for 10 edges: single toggle, then down through the wrap.
        do_reset("D_rst", R);
        for (int c = 1; c <= 3; c++) step("D_pre", up(c, 1'b0));
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        step("D_sample", up(4, 1'b0));
        step("D_sync", up(5, 1'b0));
        step("D_evt", dn(6, 1'b0));
        for (int c = 5; c >= 0; c--) step("D_down", dn(c, 1'b0));
        step("D_wrap", dn(15, 1'b1));
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        step("D_after", dn(14, 1'b0));

        // Stop and dir on the same edge while counting up.
        do_reset("E_rst", R);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        step("E_pre", up(1, 1'b0));
        step("E_pre", up(2, 1'b0));
        S = mk(3, 1'b0, 1'b0, 1'b0, S_STOP);
        step("E_evt", S);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        step("E_idle", S);
        step("E_idle", S);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        step("E_wait", S);
        step("E_wait", S);
        step("E_resume", dn(3, 1'b0));
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        step("E_after", dn(2, 1'b0));

        // Asynchronous reset between edges while counting down.
        rst_n = 1'b0;
        #1;
        exp_q.push_back(R);
        compare("H_async");
        #3 rst_n = 1'b1;
        step("H_after", up(1, 1'b0));

        // Ping-pong: dir event lands on the reversal edge and cancels it.
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        do_reset("F_rst", R);
        for (int c = 1; c <= 13; c++) step("F_pre", up(c, 1'b0));
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        step("F_sample", up(14, 1'b0));
        step("F_sync", up(15, 1'b0));
        step("F_cancel", up(14, 1'b1));
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        step("F_next", up(15, 1'b0));
        step("F_rev", dn(14, 1'b1));

        // Clear mid-count, then clear on what would be a wrap edge (pulse suppressed).
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        do_reset("G_rst", R);
        for (int c = 1; c <= 7; c++) step("G_pre", up(c, 1'b0));
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        step("G_sample", up(8, 1'b0));
        step("G_sync", up(9, 1'b0));
        step("G_clr", up(0, 1'b0));
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int c = 1; c <= 13; c++) step("G_run", up(c, 1'b0));
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        step("G_sample2", up(14, 1'b0));
        step("G_sync2", up(15, 1'b0));
        step("G_clr_bound", up(0, 1'b0));
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        step("G_after", up(1, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
